// File: rtl/adder_tree_pipe_acc.sv
// Pipelined NUM_IN-operand adder tree with optional multi-vector accumulation.
// Latency LOG2N+1 cycles; accepts one vector per cycle, no backpressure.
module adder_tree_pipe_acc #(
   parameter int NUM_IN = 8,
   parameter int IN_W   = 4,
   parameter int ACC_W  = 4,
   parameter int SIGNED = 0,
   localparam int LOG2N = $clog2(NUM_IN),
   localparam int OUT_W = IN_W + LOG2N + ACC_W
) (
   input  logic                   clk_i,
   input  logic                   reset_i,
   input  logic                   in_valid_i,
   input  logic [NUM_IN*IN_W-1:0] in_data_i,
   input  logic                   acc_mode_i,
   input  logic                   in_last_i,
   output logic                   out_valid_o,
   output logic [OUT_W-1:0]       sum_out_o,
   output logic                   out_ovf_o
);

   localparam int TW = IN_W + LOG2N;

   logic [LOG2N-1:0] vld_q, mode_q, last_q;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         vld_q  <= '0;
         mode_q <= '0;
         last_q <= '0;
      end else begin
         vld_q  <= (vld_q << 1)  | LOG2N'(in_valid_i);
         mode_q <= (mode_q << 1) | LOG2N'(acc_mode_i);
         last_q <= (last_q << 1) | LOG2N'(in_last_i);
      end
   end

   // Level 0 is the raw operands; level j holds NUM_IN>>j sums of IN_W+j bits.
   for (genvar j = 0; j <= LOG2N; j++) begin : g_lvl
      localparam int W = IN_W + j;
      localparam int N = NUM_IN >> j;
      logic [W-1:0] node [N];
      if (j == 0) begin : g_leaf
         for (genvar k = 0; k < N; k++) begin : g_op
            assign node[k] = in_data_i[k*IN_W +: IN_W];
         end
      end else begin : g_sum
         always_ff @(posedge clk_i or posedge reset_i) begin
            if (reset_i) begin
               for (int k = 0; k < N; k++) node[k] <= '0;
            end else begin
               for (int k = 0; k < N; k++) begin
                  if (SIGNED != 0)
                     node[k] <= W'($signed(g_lvl[j-1].node[2*k])) + W'($signed(g_lvl[j-1].node[2*k+1]));
                  else
                     node[k] <= W'(g_lvl[j-1].node[2*k]) + W'(g_lvl[j-1].node[2*k+1]);
               end
            end
         end
      end
   end

   logic [TW-1:0]    tsum;
   logic [OUT_W-1:0] tsum_ext;
   logic             tv, tmode, tlast;

   assign tsum  = g_lvl[LOG2N].node[0];
   assign tv    = vld_q[LOG2N-1];
   assign tmode = mode_q[LOG2N-1];
   assign tlast = last_q[LOG2N-1];

   if (SIGNED != 0) begin : g_sx
      assign tsum_ext = OUT_W'($signed(tsum));
   end else begin : g_zx
      assign tsum_ext = OUT_W'(tsum);
   end

   logic [OUT_W-1:0] acc_q, acc_d, sum_q, sum_d;
   logic             open_q, open_d, ovf_q, ovf_d, oovf_q, oovf_d, ovld_q, ovld_d;
   logic [OUT_W:0]   add_full;
   logic             carry, sovf, wrap;

   assign add_full = {1'b0, acc_q} + {1'b0, tsum_ext};
   assign carry    = add_full[OUT_W];
   assign sovf     = (acc_q[OUT_W-1] == tsum_ext[OUT_W-1]) && (add_full[OUT_W-1] != acc_q[OUT_W-1]);
   assign wrap     = (SIGNED != 0) ? sovf : carry;

   always_comb begin
      acc_d  = acc_q;
      open_d = open_q;
      ovf_d  = ovf_q;
      sum_d  = sum_q;
      oovf_d = oovf_q;
      ovld_d = 1'b0;
      if (tv) begin
         if (!tmode) begin
            acc_d  = tsum_ext;
            open_d = 1'b0;
            ovf_d  = 1'b0;
            sum_d  = tsum_ext;
            oovf_d = 1'b0;
            ovld_d = 1'b1;
         end else begin
            if (!open_q) begin
               acc_d  = tsum_ext;
               ovf_d  = 1'b0;
               open_d = 1'b1;
            end else begin
               acc_d = add_full[OUT_W-1:0];
               ovf_d = ovf_q | wrap;
            end
            // The closing vector emits the freshly updated accumulator on the same edge.
            if (tlast) begin
               sum_d  = acc_d;
               oovf_d = ovf_d;
               ovld_d = 1'b1;
               open_d = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         acc_q  <= '0;
         open_q <= 1'b0;
         ovf_q  <= 1'b0;
         sum_q  <= '0;
         oovf_q <= 1'b0;
         ovld_q <= 1'b0;
      end else begin
         acc_q  <= acc_d;
         open_q <= open_d;
         ovf_q  <= ovf_d;
         sum_q  <= sum_d;
         oovf_q <= oovf_d;
         ovld_q <= ovld_d;
      end
   end

   assign out_valid_o = ovld_q;
   assign sum_out_o   = sum_q;
   assign out_ovf_o   = oovf_q;

endmodule

// File: tb/tb_adder_tree_pipe_acc.sv
// Bench for adder_tree_pipe_acc: unsigned and signed instances share stimulus;
// a behavioural model pushes expected emissions that the output monitor pops.
module tb_adder_tree_pipe_acc;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic [31:0] in_data = '0;
   logic        acc_mode = 1'b0;
   logic        in_last = 1'b0;
   logic        u_vld, u_ovf, s_vld, s_ovf;
   logic [10:0] u_sum, s_sum;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   typedef struct {
      int          cyc;
      logic [10:0] us;
      logic [10:0] ss;
      logic        uo;
      logic        so;
   } exp_t;

   exp_t sbq[$];
   exp_t mon_e;

   int   u_acc, s_acc;
   logic u_ov, s_ov, grp_open;
   logic [10:0] hold_us, hold_ss;
   logic        hold_uo, hold_so;

   adder_tree_pipe_acc #(.NUM_IN(8), .IN_W(4), .ACC_W(4), .SIGNED(0)) u_dut (
      .clk_i(clk), .reset_i(reset), .in_valid_i(in_valid), .in_data_i(in_data),
      .acc_mode_i(acc_mode), .in_last_i(in_last),
      .out_valid_o(u_vld), .sum_out_o(u_sum), .out_ovf_o(u_ovf));

   adder_tree_pipe_acc #(.NUM_IN(8), .IN_W(4), .ACC_W(4), .SIGNED(1)) u_sdut (
      .clk_i(clk), .reset_i(reset), .in_valid_i(in_valid), .in_data_i(in_data),
      .acc_mode_i(acc_mode), .in_last_i(in_last),
      .out_valid_o(s_vld), .sum_out_o(s_sum), .out_ovf_o(s_ovf));

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   task automatic model_reset();
      grp_open = 1'b0;
      u_acc = 0;
      s_acc = 0;
      u_ov = 1'b0;
      s_ov = 1'b0;
      sbq.delete();
   endtask

   task automatic model_step(input logic [31:0] d, input logic mode, input logic last);
      int tu, ts, full, f;
      logic [3:0] op;
      exp_t e;
      tu = 0;
      ts = 0;
      for (int k = 0; k < 8; k++) begin
         op = d[k*4 +: 4];
         tu += int'(op);
         ts += op[3] ? int'(op) - 16 : int'(op);
      end
      e.cyc = cyc + 4;
      e.uo = 1'b0;
      e.so = 1'b0;
      if (!mode) begin
         grp_open = 1'b0;
         u_acc = tu;
         s_acc = ts;
         e.us = 11'(tu);
         e.ss = 11'(ts & 2047);
         sbq.push_back(e);
      end else begin
         if (!grp_open) begin
            u_acc = tu;
            s_acc = ts;
            u_ov = 1'b0;
            s_ov = 1'b0;
            grp_open = 1'b1;
         end else begin
            full = u_acc + tu;
            if (full >= 2048) u_ov = 1'b1;
            u_acc = full & 2047;
            full = s_acc + ts;
            if (full > 1023 || full < -1024) s_ov = 1'b1;
            f = full & 2047;
            s_acc = (f >= 1024) ? f - 2048 : f;
         end
         if (last) begin
            e.us = 11'(u_acc);
            e.ss = 11'(s_acc & 2047);
            e.uo = u_ov;
            e.so = s_ov;
            sbq.push_back(e);
            grp_open = 1'b0;
         end
      end
   endtask

   task automatic drive(input logic [31:0] d, input logic mode, input logic last);
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_data  = d;
      acc_mode = mode;
      in_last  = last;
      model_step(d, mode, last);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         in_valid = 1'b0;
         in_data  = $urandom;
         acc_mode = 1'($urandom);
         in_last  = 1'($urandom);
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sbq.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      checks++;
      assert (sbq.size() == 0) else begin
         errors++;
         $error("FAIL drain: observed pending=%0d required 0", sbq.size());
      end
      sbq.delete();
   endtask

   task automatic async_reset_check();
      @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      checks++;
      assert ({u_vld, u_sum, u_ovf, s_vld, s_sum, s_ovf} === 26'h0) else begin
         errors++;
         $error("FAIL async_reset: observed %0h required 0", {u_vld, u_sum, u_ovf, s_vld, s_sum, s_ovf});
      end
      model_reset();
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   // Output monitor: every emission is matched against the scoreboard, every
   // other cycle must hold the last emitted value.
   always @(negedge clk) begin
      if (reset) begin
         checks++;
         assert ({u_vld, u_sum, u_ovf, s_vld, s_sum, s_ovf} === 26'h0) else begin
            errors++;
            $error("FAIL reset_state: observed %0h required 0", {u_vld, u_sum, u_ovf, s_vld, s_sum, s_ovf});
         end
         hold_us = '0;
         hold_ss = '0;
         hold_uo = 1'b0;
         hold_so = 1'b0;
      end else if (u_vld === 1'b1 || s_vld === 1'b1) begin
         checks++;
         assert (sbq.size() != 0) else begin
            errors++;
            $error("FAIL unexpected_pulse: observed pending=0 required >0 at cycle %0d", cyc);
         end
         if (sbq.size() != 0) begin
            mon_e = sbq.pop_front();
            checks++;
            assert (cyc === mon_e.cyc) else begin
               errors++;
               $error("FAIL latency: observed cycle %0d required %0d", cyc, mon_e.cyc);
            end
            checks++;
            assert ({u_vld, s_vld} === 2'b11) else begin
               errors++;
               $error("FAIL valid_pair: observed %b required 11", {u_vld, s_vld});
            end
            checks++;
            assert (u_sum === mon_e.us) else begin
               errors++;
               $error("FAIL u_sum: observed %0d required %0d", u_sum, mon_e.us);
            end
            checks++;
            assert (u_ovf === mon_e.uo) else begin
               errors++;
               $error("FAIL u_ovf: observed %b required %b", u_ovf, mon_e.uo);
            end
            checks++;
            assert (s_sum === mon_e.ss) else begin
               errors++;
               $error("FAIL s_sum: observed %h required %h", s_sum, mon_e.ss);
            end
            checks++;
            assert (s_ovf === mon_e.so) else begin
               errors++;
               $error("FAIL s_ovf: observed %b required %b", s_ovf, mon_e.so);
            end
            hold_us = mon_e.us;
            hold_ss = mon_e.ss;
            hold_uo = mon_e.uo;
            hold_so = mon_e.so;
         end
      end else begin
         checks++;
         assert ({u_sum, u_ovf, s_sum, s_ovf} === {hold_us, hold_uo, hold_ss, hold_so}) else begin
            errors++;
            $error("FAIL hold: observed %h required %h", {u_sum, u_ovf, s_sum, s_ovf},
                   {hold_us, hold_uo, hold_ss, hold_so});
         end
      end
   end

   initial begin
      model_reset();
      repeat (4) begin
         @(posedge clk);
         #1;
         in_valid = 1'($urandom);
         in_data  = $urandom;
         acc_mode = 1'($urandom);
         in_last  = 1'($urandom);
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
      in_valid = 1'b0;
      model_reset();

      // single pass-through vector, operands 1..8
      drive(32'h8765_4321, 1'b0, 1'b0);
      idle(1);
      drain();

      // ten back-to-back all-15 vectors
      repeat (10) drive(32'hFFFF_FFFF, 1'b0, 1'b0);
      idle(1);
      drain();

      // three-vector group, then a single-vector group with no bubble
      drive(32'hFFFF_FFFF, 1'b1, 1'b0);
      drive(32'hFFFF_FFFF, 1'b1, 1'b0);
      drive(32'hFFFF_FFFF, 1'b1, 1'b1);
      drive(32'h8765_4321, 1'b1, 1'b1);
      idle(1);
      drain();

      // eighteen-vector group wraps; following two-vector group clears the flag
      repeat (17) drive(32'hFFFF_FFFF, 1'b1, 1'b0);
      drive(32'hFFFF_FFFF, 1'b1, 1'b1);
      drive(32'hFFFF_FFFF, 1'b1, 1'b0);
      drive(32'hFFFF_FFFF, 1'b1, 1'b1);
      idle(1);
      drain();

      // idle gap inside a group
      drive(32'h1111_1111, 1'b1, 1'b0);
      idle(3);
      drive(32'h2222_2222, 1'b1, 1'b1);
      idle(1);
      drain();

      // pass-through vector discards an open group
      drive(32'hFFFF_FFFF, 1'b1, 1'b0);
      drive(32'h8765_4321, 1'b0, 1'b0);
      drive(32'h1111_1111, 1'b1, 1'b1);
      idle(1);
      drain();

      // all operands -8 (signed instance: -64)
      drive(32'h8888_8888, 1'b0, 1'b0);
      idle(1);
      drain();

      // reset in the middle of an open group
      drive(32'hFFFF_FFFF, 1'b1, 1'b0);
      drive(32'hFFFF_FFFF, 1'b1, 1'b0);
      idle(6);
      async_reset_check();
      drive(32'h8765_4321, 1'b1, 1'b1);
      idle(1);
      drain();

      idle(4);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
